// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control with memory handshakes, retire counter and sticky trap
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             halt,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
  localparam int TW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
  logic [2:0] nst;
  logic req_q, is_alu, is_ld, is_st, is_br, legal, busy, acked, tmo;
  logic [TW-1:0] tcnt;
  assign is_alu = opcode inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  assign is_ld = opcode == 7'b0000011;
  assign is_st = opcode == 7'b0100011;
  assign is_br = opcode == 7'b1100011;
  assign legal = is_alu | is_ld | is_st | is_br;
  assign busy = imem_req | dmem_req;
  assign acked = (imem_req & imem_ack) | (dmem_req & dmem_ack);
  // the final waiting cycle traps unless the ack lands in that same cycle
  assign tmo = MEM_TIMEOUT != 0 && busy && !acked && tcnt == TW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_F;
    else state <= nst;
  always_comb begin
    nst = state;
    case (state)
      S_F: nst = tmo ? S_T : (imem_req && imem_ack) ? S_D : S_F;
      S_D: nst = legal ? S_E : S_T;
      S_E: nst = (is_ld || is_st) ? S_M : is_br ? S_F : S_W;
      S_M: nst = tmo ? S_T : dmem_ack ? (is_ld ? S_W : S_F) : S_M;
      S_W: nst = S_F;
      default: nst = S_T;
    endcase
  end
  // outputs are forced low while rst is held, since state alone reads FETCH then
  always_comb begin
    imem_req = !rst && state == S_F && (req_q || !halt);
    ir_we = imem_req && imem_ack;
    dmem_req = !rst && state == S_M;
    dmem_we = dmem_req && is_st;
    rf_we = !rst && state == S_W;
    pc_we = !rst && ((state == S_E && is_br) || (dmem_req && dmem_ack && is_st) || state == S_W);
    trap = state == S_T;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_q <= 1'b0;
      tcnt <= '0;
      trap_cause <= 2'b00;
      instret <= '0;
    end else begin
      req_q <= imem_req && !imem_ack && nst == S_F;
      tcnt <= (busy && !acked && nst == state) ? tcnt + 1'b1 : '0;
      if (nst == S_T && state != S_T) trap_cause <= state == S_D ? 2'b01 : state == S_F ? 2'b10 : 2'b11;
      if (pc_we) instret <= instret + 1'b1;
    end
endmodule
